// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared code constants and segment patterns for the seven-segment scanner
//
// Purpose: code width, special code values and active-low segment patterns
// ({a,b,c,d,e,f,g} on bits [6:0]) shared by seg7_decode and seg_scan_mux.
// Ports: none (package).
package seg_pkg;

  localparam int SEG_CODE_W = 5;

  typedef logic [SEG_CODE_W-1:0] seg_code_t;
  typedef logic [6:0]            seg_pat_t;

  localparam seg_code_t SEG_CODE_DASH  = 5'd16;
  localparam seg_code_t SEG_CODE_BLANK = 5'd17;

  localparam seg_pat_t SEG_PAT_OFF  = 7'b1111111;
  localparam seg_pat_t SEG_PAT_DASH = 7'b1111110;

  // Entry n is the pattern for hex value n (0-9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] SEG_PAT_HEX = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 5-bit code to active-low 7-segment decoder
//
// Purpose: codes 0-15 show hex digits, 16 shows a dash, 17-31 are blank.
// Ports:
//   code  - 5-bit display code
//   seg_n - segments {a,b,c,d,e,f,g} on [6:0], active-low
module seg7_decode
  import seg_pkg::*;
(
  input  logic [SEG_CODE_W-1:0] code,
  output logic [6:0]            seg_n
);

  always_comb begin
    seg_n = SEG_PAT_OFF;
    if (code[4] == 1'b0) begin
      seg_n = SEG_PAT_HEX[code[3:0]];
    end else if (code == SEG_CODE_DASH) begin
      seg_n = SEG_PAT_DASH;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed seven-segment display scanner with double-buffered data
//
// Purpose: time-multiplexes NUM_DIGITS digits, REFRESH_DIV clocks per digit slot,
// with BLANK_CYC anode-off guard cycles at the start of each slot. New data
// loaded with load is held pending and committed only at the end of a frame.
// Optional macro SEG_BLINK_EN adds per-digit blinking (blink_mask, BLINK_DIV).
// Ports:
//   clk, rst_n  - clock (rising edge), synchronous active-low reset
//   enable      - scan enable; low blanks the display and parks the scan at digit 0
//   digits_in   - 5-bit code per digit, digit k at [5k+4:5k], digit 0 rightmost
//   dp_in       - decimal point per digit, 1 = lit
//   load        - one-cycle strobe capturing digits_in/dp_in into the pending buffer
//   blink_mask  - per-digit blink select (SEG_BLINK_EN only)
//   seg_n, dp_n - registered active-low segments and decimal point
//   an_n        - registered active-low anodes, at most one low
//   frame_done  - one-cycle pulse at each scan wrap
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [SEG_CODE_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]          dp_in,
  input  logic                           load,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]          blink_mask,
`endif
  output logic [6:0]                     seg_n,
  output logic                           dp_n,
  output logic [NUM_DIGITS-1:0]          an_n,
  output logic                           frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int BUF_W = SEG_CODE_W * NUM_DIGITS;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(BLANK_CYC);

  // Elaboration-time parameter range checks.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_mux: NUM_DIGITS out of range");
  end
  if (REFRESH_DIV < 4 || BLANK_CYC < 1 || BLANK_CYC > REFRESH_DIV - 2) begin : g_bad_slot
    $error("seg_scan_mux: REFRESH_DIV/BLANK_CYC out of range");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("seg_scan_mux: BLINK_DIV out of range");
  end

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [BUF_W-1:0]      pend_codes, disp_codes;
  logic [NUM_DIGITS-1:0] pend_dp, disp_dp;
  logic                  pend;
  logic                  slot_last, frame_wrap, blank_digit;
  logic [SEG_CODE_W-1:0] cur_code;
  logic [6:0]            dec_seg;

  assign slot_last  = (div_cnt == DIV_LAST);
  assign frame_wrap = enable && slot_last && (idx == IDX_LAST);
  assign cur_code   = disp_codes[idx*SEG_CODE_W +: SEG_CODE_W];

  seg7_decode u_decode (
    .code  (cur_code),
    .seg_n (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_last) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A load landing on the frame wrap bypasses the pending buffer so it is
  // shown in the very next frame; otherwise the latest pending load commits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_codes <= {NUM_DIGITS{SEG_CODE_BLANK}};
      disp_codes <= {NUM_DIGITS{SEG_CODE_BLANK}};
      pend_dp    <= '0;
      disp_dp    <= '0;
      pend       <= 1'b0;
    end else begin
      if (load) begin
        pend_codes <= digits_in;
        pend_dp    <= dp_in;
      end
      if (frame_wrap) begin
        pend <= 1'b0;
        if (load) begin
          disp_codes <= digits_in;
          disp_dp    <= dp_in;
        end else if (pend) begin
          disp_codes <= pend_codes;
          disp_dp    <= pend_dp;
        end
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank_digit = blink_phase & blink_mask[idx];
`else
  assign blank_digit = 1'b0;
`endif

  // Segment data follows the selected digit even in the guard cycles;
  // only the anodes are held off there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= SEG_PAT_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (!enable) begin
        an_n  <= '1;
        seg_n <= SEG_PAT_OFF;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= (div_cnt < GUARD_END) ? '1 : ~(NUM_DIGITS'(1) << idx);
        seg_n <= blank_digit ? SEG_PAT_OFF : dec_seg;
        dp_n  <= blank_digit | ~disp_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed self-checking bench for seg_scan_mux (4 digits, 8-cycle slots)
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [19:0] digits_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  blink_mask;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYC   (1),
    .BLINK_DIV   (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
`ifdef SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_off(input string tag);
    check({tag, " an"}, {28'd0, an_n}, 32'hF);
    check({tag, " seg"}, {25'd0, seg_n}, 32'h7F);
    check({tag, " dp"}, {31'd0, dp_n}, 32'h1);
    check({tag, " fd"}, {31'd0, frame_done}, 32'h0);
  endtask

  // One full 32-cycle output frame; pats[k]/dps[k] are what digit k must show.
  // Optional loads are strobed so they are sampled at edge j (0..31) of the frame.
  task automatic check_frame(input string name, input logic [3:0][6:0] pats, input logic [3:0] dps,
                             input int la, input logic [19:0] da, input logic [3:0] pa,
                             input int lb, input logic [19:0] db, input logic [3:0] pb);
    for (int j = 0; j < 32; j++) begin
      int slot;
      logic [3:0] ea;
      slot = j / 8;
      if (j == la) begin
        digits_in = da; dp_in = pa; load = 1'b1;
      end else if (j == lb) begin
        digits_in = db; dp_in = pb; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      load = 1'b0;
      ea = (j % 8 == 0) ? 4'hF : ~(4'b0001 << slot);
      check($sformatf("%s an j=%0d", name, j), {28'd0, an_n}, {28'd0, ea});
      check($sformatf("%s seg j=%0d", name, j), {25'd0, seg_n}, {25'd0, pats[slot]});
      check($sformatf("%s dp j=%0d", name, j), {31'd0, dp_n}, {31'd0, ~dps[slot]});
      check($sformatf("%s fd j=%0d", name, j), {31'd0, frame_done}, {31'd0, (j == 31)});
    end
  endtask

  localparam logic [6:0] P_OFF = 7'h7F;

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    digits_in = '0; dp_in = '0; blink_mask = 4'b0000;

    // Reset held three cycles.
    repeat (3) tick();
    check_off("reset");

    // Load {3,2,1,0} while idle, then start scanning.
    rst_n = 1'b1;
    digits_in = {5'd3, 5'd2, 5'd1, 5'd0}; dp_in = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    check_off("idle_after_load");
    enable = 1'b1;

    // Frame 0 still shows the reset blanks; pending data commits at its wrap.
    check_frame("f0", {P_OFF, P_OFF, P_OFF, P_OFF}, 4'b0000,
                -1, '0, '0, -1, '0, '0);
    // Digits 0..3 show 0,1,2,3; load all 8s mid-frame, old data must hold.
    check_frame("f1", {7'h06, 7'h12, 7'h4F, 7'h01}, 4'b0000,
                12, {4{5'd8}}, 4'b0101, -1, '0, '0);
    // All 8s with dp pattern; load on the wrap cycle itself.
    check_frame("f2", {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0101,
                31, {5'd25, 5'd17, 5'd16, 5'd5}, 4'b0000, -1, '0, '0);
    // Codes 5,16,17,25; two loads in this frame, the later must win.
    check_frame("f3", {P_OFF, P_OFF, 7'h7E, 7'h24}, 4'b0000,
                5, {4{5'd7}}, 4'b1111, 20, {5'd12, 5'd11, 5'd10, 5'd9}, 4'b1000);
    // Codes 9,A,b,C; load d/E/F on the wrap.
    check_frame("f4", {7'h31, 7'h60, 7'h08, 7'h04}, 4'b1000,
                31, {5'd15, 5'd14, 5'd13, 5'd7}, 4'b0000, -1, '0, '0);
    check_frame("f5", {7'h38, 7'h30, 7'h42, 7'h0F}, 4'b0000,
                -1, '0, '0, -1, '0, '0);

    // Run into slot 2 of the next frame, then drop enable.
    repeat (18) tick();
    enable = 1'b0;
    tick();
    check_off("disable");
    digits_in = {4{5'd4}}; dp_in = 4'b1111; load = 1'b1;
    tick();
    load = 1'b0;
    check_off("disable_load");
    tick();

    // Re-enable: scan restarts at digit 0 with the old display data.
    enable = 1'b1;
    tick();
    check("reen guard an", {28'd0, an_n}, 32'hF);
    check("reen guard seg", {25'd0, seg_n}, 32'h0F);
    tick();
    check("reen d0 an", {28'd0, an_n}, 32'hE);
    check("reen d0 seg", {25'd0, seg_n}, 32'h0F);
    check("reen d0 fd", {31'd0, frame_done}, 32'h0);

    // Reset with a pending load: blanks return and the pending 4s never show.
    rst_n = 1'b0;
    tick();
    check_off("mid_reset");
    rst_n = 1'b1;
    check_frame("r0", {P_OFF, P_OFF, P_OFF, P_OFF}, 4'b0000,
                -1, '0, '0, -1, '0, '0);
    check_frame("r1", {P_OFF, P_OFF, P_OFF, P_OFF}, 4'b0000,
                -1, '0, '0, -1, '0, '0);

`ifdef SEG_BLINK_EN
    // Blink phase flips every 64 cycles counted from reset; digit 0 blinks.
    rst_n = 1'b0; enable = 1'b1; blink_mask = 4'b0001;
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      int slot;
      logic [3:0] ea;
      logic [6:0] es;
      if (n == 1) begin
        digits_in = {4{5'd8}}; dp_in = 4'b0000; load = 1'b1;
      end
      tick();
      load = 1'b0;
      slot = ((n - 1) % 32) / 8;
      ea = ((n - 1) % 8 == 0) ? 4'hF : ~(4'b0001 << slot);
      es = (n <= 32) ? P_OFF :
           ((slot == 0) && (((n - 1) / 64) % 2 == 1)) ? P_OFF : 7'h00;
      check($sformatf("blink an n=%0d", n), {28'd0, an_n}, {28'd0, ea});
      check($sformatf("blink seg n=%0d", n), {25'd0, seg_n}, {25'd0, es});
      check($sformatf("blink fd n=%0d", n), {31'd0, frame_done}, {31'd0, (n % 32 == 0)});
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
